// File: rtl/product_bcd_converter_pkg.sv
// Shared constants for the product binary-to-BCD converter.
// State encoding and double-dabble digit adjust values.
package product_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/product_bcd_converter_adjust.sv
// Single BCD digit pre-shift correction for double-dabble.
// Adds 3 to any digit of 5 or more; otherwise passes it through.
module bcd_digit_adjust
  import product_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  assign adj = (digit >= ADJ_THRESH) ? digit + ADJ_ADD : digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: one bit per clock,
// start/done handshake, result held until the next conversion.
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = DIGIT_W * DIGITS;

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_sh;
  logic [SW-1:0]   scr_q;
  logic [SW-1:0]   scr_adj;
  logic [SW-1:0]   scr_sh;
  logic [CW-1:0]   cnt_q;
  logic            last;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit (scr_q[k*DIGIT_W +: DIGIT_W]),
      .adj   (scr_adj[k*DIGIT_W +: DIGIT_W])
    );
  end

  assign bin_sh = {bin_q[WIDTH-2:0], 1'b0};
  assign scr_sh = {scr_adj[SW-2:0], bin_q[WIDTH-1]};
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // bcd is loaded on the final shift edge so it is valid during DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            bin_q <= bin_in;
            scr_q <= '0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          bin_q <= bin_sh;
          scr_q <= scr_sh;
          cnt_q <= cnt_q + 1'b1;
          if (last) bcd <= scr_sh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter against a
// decimal arithmetic reference model.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic [11:0] bcd;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bin_in (bin_in),
    .bcd    (bcd),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start is sampled at the next rising edge (edge E)
  task automatic launch(input logic [7:0] v);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // samples the cycles after edges E, E+1, ... E+n-1
  task automatic observe(input int n, input logic [11:0] prev,
                         output int dcnt, output int dfirst,
                         output int bcnt, output logic [11:0] res,
                         output bit held);
    dcnt = 0; dfirst = -1; bcnt = 0; res = 'x; held = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bin_in = 8'($urandom);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        dcnt++;
        if (dfirst < 0) dfirst = i;
        res = bcd;
      end else if (dcnt == 0 && bcd !== prev) begin
        held = 1'b0;
      end
    end
  endtask

  logic [11:0] last_res = 12'h000;

  task automatic conv(input int v, input string tag);
    int dc, df, bc;
    logic [11:0] r;
    bit h;
    launch(8'(v));
    observe(10, last_res, dc, df, bc, r, h);
    check({tag, "_done_at"}, 32'(df), 32'd8);
    check({tag, "_done_n"}, 32'(dc), 32'd1);
    check({tag, "_busy_n"}, 32'(bc), 32'd9);
    check({tag, "_hold"}, {31'd0, h}, 32'd1);
    check({tag, "_val"}, {20'd0, r}, {20'd0, ref_bcd(v)});
    last_res = ref_bcd(v);
  endtask

  initial begin
    int dc, idx;
    int dq[$];
    bit ok;
    reset = 1'b1; start = 1'b0; bin_in = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bcd", {20'd0, bcd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    conv(0, "zero");
    conv(225, "max_prod");
    repeat (5) @(negedge clk);
    check("hold_225", {20'd0, bcd}, 32'h225);
    conv(255, "b2b255");
    conv(99, "b2b099");
    conv(100, "b2b100");

    // second start during SHIFT is ignored
    launch(8'd42);
    dc = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 2) begin start = 1'b1; bin_in = 8'd7; end
      else begin start = 1'b0; bin_in = 8'($urandom); end
      if (done === 1'b1) begin
        dc++;
        check("ign_val", {20'd0, bcd}, {20'd0, ref_bcd(42)});
      end
    end
    check("ign_done_n", 32'(dc), 32'd1);
    check("ign_hold", {20'd0, bcd}, 32'h042);
    last_res = 12'h042;

    // reset sampled at E+4 aborts the conversion
    launch(8'd200);
    repeat (3) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_bcd", {20'd0, bcd}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    check("abort_no_done", 32'(dc), 32'd0);
    last_res = 12'h000;
    conv(13, "after_abort");

    // start held high: one conversion every 10 cycles
    @(negedge clk);
    start = 1'b1; bin_in = 8'd64;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 39) start = 1'b0;
      if (done === 1'b1) begin
        dq.push_back(i);
        check("held_val", {20'd0, bcd}, 32'h064);
      end
    end
    check("held_n", 32'(dq.size()), 32'd4);
    for (int k = 1; k < dq.size(); k++)
      check("held_period", 32'(dq[k] - dq[k-1]), 32'd10);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    check("held_idle", {31'd0, ok}, 32'd1);
    last_res = 12'h064;

    for (int v = 0; v < 256; v++) conv(v, "exh");
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 255));
      conv(idx, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
